// File: rtl/decode_queue.sv
// decode_queue: RV32IMA+S decode stage between fetch and execute.
// Each accepted word is decoded in the cycle it is accepted. The decoded
// entry is then held in a small FIFO, so execute can apply backpressure
// without stalling the decode logic. flush discards the whole queue.
module decode_queue #(
    parameter int DEPTH    = 2,
    parameter bit ENABLE_M = 1'b1,
    parameter bit ENABLE_A = 1'b1
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  in_pc,
    input  logic [31:0]                  in_instr,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_pc,
    output logic [31:0]                  out_instr,
    output logic [4:0]                   out_rd,
    output logic [4:0]                   out_rs1,
    output logic [4:0]                   out_rs2,
    output logic [31:0]                  out_imm,
    output logic [2:0]                   out_fmt,
    output logic                         out_writes_reg,
    output logic                         out_is_load,
    output logic                         out_is_store,
    output logic                         out_is_branch,
    output logic                         out_csrop,
    output logic                         out_rv32a,
    output logic                         out_illegal,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // Major opcodes (ir[6:0])
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_AMO      = 7'b0101111;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // Format codes presented on out_fmt
    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_R    = 3'd1;
    localparam logic [2:0] FMT_I    = 3'd2;
    localparam logic [2:0] FMT_S    = 3'd3;
    localparam logic [2:0] FMT_B    = 3'd4;
    localparam logic [2:0] FMT_U    = 3'd5;
    localparam logic [2:0] FMT_J    = 3'd6;

    // funct7 values that select the base, alternate and multiply groups in OP
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;
    localparam logic [6:0] F7_SFENCE = 7'b0001001;

    localparam logic [4:0] F5_LR = 5'b00010;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        writes_reg;
        logic        is_load;
        logic        is_store;
        logic        is_branch;
        logic        csrop;
        logic        rv32a;
        logic        illegal;
    } entry_t;

    // Raw instruction fields
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] funct5;
    logic [4:0] rd_field;
    logic [4:0] rs1_field;
    logic [4:0] rs2_field;

    assign opcode    = in_instr[6:0];
    assign rd_field  = in_instr[11:7];
    assign funct3    = in_instr[14:12];
    assign rs1_field = in_instr[19:15];
    assign rs2_field = in_instr[24:20];
    assign funct7    = in_instr[31:25];
    assign funct5    = in_instr[31:27];

    // Classification results before masking
    logic [2:0] dec_fmt;
    logic       dec_legal;
    logic       dec_writes;
    logic       dec_load;
    logic       dec_store;
    logic       dec_branch;
    logic       dec_csr;
    logic       dec_amo;
    logic       amo_funct_ok;
    logic       sys_priv_ok;
    entry_t     dec;

    // Queue state
    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic            push;
    logic            pop;
    entry_t          head;

    // ecall, ebreak, sret, mret and wfi are exact words; sfence.vma takes any rs1/rs2
    assign sys_priv_ok = (in_instr == 32'h0000_0073) || (in_instr == 32'h0010_0073) ||
                         (in_instr == 32'h1020_0073) || (in_instr == 32'h3020_0073) ||
                         (in_instr == 32'h1050_0073) ||
                         ((funct7 == F7_SFENCE) && (rd_field == 5'd0));

    // Recognise defined AMO funct5 codes; LR must carry rs2 = x0
    always_comb begin
        amo_funct_ok = 1'b0;
        case (funct5)
            F5_LR:    amo_funct_ok = (rs2_field == 5'd0);
            5'b00011, 5'b00001, 5'b00000, 5'b00100, 5'b01100,
            5'b01000, 5'b10000, 5'b10100, 5'b11000, 5'b11100:
                      amo_funct_ok = 1'b1;
            default:  amo_funct_ok = 1'b0;
        endcase
    end

    // Classify by opcode: format, instruction class and funct-field legality
    always_comb begin
        dec_fmt    = FMT_NONE;
        dec_legal  = 1'b0;
        dec_writes = 1'b0;
        dec_load   = 1'b0;
        dec_store  = 1'b0;
        dec_branch = 1'b0;
        dec_csr    = 1'b0;
        dec_amo    = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                dec_fmt    = FMT_U;
                dec_legal  = 1'b1;
                dec_writes = 1'b1;
            end
            OPC_JAL: begin
                dec_fmt    = FMT_J;
                dec_legal  = 1'b1;
                dec_writes = 1'b1;
            end
            OPC_JALR: begin
                dec_fmt    = FMT_I;
                dec_legal  = 1'b1;
                dec_writes = 1'b1;
            end
            OPC_LOAD: begin
                // lb, lh, lw, lbu, lhu
                dec_fmt    = FMT_I;
                dec_legal  = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
                dec_writes = 1'b1;
                dec_load   = 1'b1;
            end
            OPC_STORE: begin
                // sb, sh, sw
                dec_fmt   = FMT_S;
                dec_legal = !funct3[2] && (funct3[1:0] != 2'b11);
                dec_store = 1'b1;
            end
            OPC_BRANCH: begin
                // funct3 010 and 011 are unassigned
                dec_fmt    = FMT_B;
                dec_legal  = (funct3[2:1] != 2'b01);
                dec_branch = 1'b1;
            end
            OPC_OP_IMM: begin
                dec_fmt    = FMT_I;
                dec_writes = 1'b1;
                case (funct3)
                    3'b001:  dec_legal = (funct7 == F7_BASE);
                    3'b101:  dec_legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    default: dec_legal = 1'b1;
                endcase
            end
            OPC_MISC_MEM: begin
                dec_fmt   = FMT_I;
                dec_legal = 1'b1;
            end
            OPC_OP: begin
                dec_fmt    = FMT_R;
                dec_writes = 1'b1;
                if (funct7 == F7_MUL) begin
                    dec_legal = ENABLE_M;
                end else if (funct7 == F7_BASE) begin
                    dec_legal = 1'b1;
                end else if (funct7 == F7_ALT) begin
                    dec_legal = (funct3 == 3'b000) || (funct3 == 3'b101);
                end else begin
                    dec_legal = 1'b0;
                end
            end
            OPC_AMO: begin
                dec_fmt    = FMT_R;
                dec_writes = 1'b1;
                dec_legal  = ENABLE_A && (funct3 == 3'b010) && amo_funct_ok;
                dec_amo    = (funct5 != F5_LR);
            end
            OPC_SYSTEM: begin
                dec_fmt = FMT_I;
                if (funct3 == 3'b000) begin
                    dec_legal = sys_priv_ok;
                end else begin
                    // funct3 100 has no CSR meaning and is passed through as a non-CSR op
                    dec_legal  = 1'b1;
                    dec_csr    = (funct3 != 3'b100);
                    dec_writes = (funct3 != 3'b100);
                end
            end
            default: begin
                dec_fmt   = FMT_NONE;
                dec_legal = 1'b0;
            end
        endcase
    end

    // Assemble the entry: zero unused fields, build the immediate, gate flags on legality
    always_comb begin
        dec       = '0;
        dec.pc    = in_pc;
        dec.instr = in_instr;
        dec.fmt   = dec_fmt;

        if (dec_legal && ((dec_fmt == FMT_R) || (dec_fmt == FMT_I) ||
                          (dec_fmt == FMT_U) || (dec_fmt == FMT_J))) begin
            dec.rd = rd_field;
        end
        if ((dec_fmt == FMT_R) || (dec_fmt == FMT_I) ||
            (dec_fmt == FMT_S) || (dec_fmt == FMT_B)) begin
            dec.rs1 = rs1_field;
        end
        if ((dec_fmt == FMT_R) || (dec_fmt == FMT_S) || (dec_fmt == FMT_B)) begin
            dec.rs2 = rs2_field;
        end

        case (dec_fmt)
            FMT_I:   dec.imm = {{20{in_instr[31]}}, in_instr[31:20]};
            FMT_S:   dec.imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            FMT_B:   dec.imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                in_instr[30:25], in_instr[11:8], 1'b0};
            FMT_U:   dec.imm = {in_instr[31:12], 12'b0};
            FMT_J:   dec.imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                in_instr[20], in_instr[30:21], 1'b0};
            default: dec.imm = 32'd0;
        endcase

        dec.writes_reg = dec_legal && dec_writes && (dec.rd != 5'd0);
        dec.is_load    = dec_legal && dec_load;
        dec.is_store   = dec_legal && dec_store;
        dec.is_branch  = dec_legal && dec_branch;
        dec.csrop      = dec_legal && dec_csr;
        dec.rv32a      = dec_legal && dec_amo;
        dec.illegal    = !dec_legal;
    end

    // Handshakes; in_ready looks only at registered occupancy, never at out_ready
    assign in_ready  = rstn && (count_reg < FULL_COUNT);
    assign out_valid = (count_reg != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;
    assign count     = count_reg;

    // Pointer and occupancy update; reset and flush both return the queue to empty
    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Entry storage: cleared by reset, written at the write pointer on push
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr_reg] <= dec;
        end
    end

    // Head entry, forced to zero whenever nothing is presented
    assign head = out_valid ? mem[rd_ptr_reg] : '0;

    assign out_pc         = head.pc;
    assign out_instr      = head.instr;
    assign out_rd         = head.rd;
    assign out_rs1        = head.rs1;
    assign out_rs2        = head.rs2;
    assign out_imm        = head.imm;
    assign out_fmt        = head.fmt;
    assign out_writes_reg = head.writes_reg;
    assign out_is_load    = head.is_load;
    assign out_is_store   = head.is_store;
    assign out_is_branch  = head.is_branch;
    assign out_csrop      = head.csrop;
    assign out_rv32a      = head.rv32a;
    assign out_illegal    = head.illegal;

endmodule
